// File: rtl/lcd_image_window.sv
// rtl/lcd_image_window.sv - places a scaled, linearly addressed ROM image anywhere in the visible LCD area
module lcd_image_window #(
  parameter int H_ACT       = 800,
  parameter int V_ACT       = 480,
  parameter int IMG_W       = 200,
  parameter int IMG_H       = 120,
  parameter int SCALE_SH    = 2,
  parameter int COLOR_DEPTH = 1,
  parameter int ROM_LAT     = 1,
  parameter logic [COLOR_DEPTH-1:0] BG_COLOR = '0,
  localparam int N_COL  = (H_ACT > 1) ? $clog2(H_ACT) : 1,
  localparam int N_FIL  = (V_ACT > 1) ? $clog2(V_ACT) : 1,
  localparam int ADDR_W = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic                   DEN,
  input  logic [N_FIL-1:0]       fila,
  input  logic [N_COL-1:0]       columna,
  input  logic                   enable,
  input  logic [N_COL-1:0]       pos_x,
  input  logic [N_FIL-1:0]       pos_y,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [COLOR_DEPTH-1:0] rom_q,
  output logic [COLOR_DEPTH-1:0] pix_out,
  output logic                   pix_hit,
  output logic                   pix_den
);

  localparam int S     = 1 << SCALE_SH;
  localparam int WIN_W = IMG_W * S;
  localparam int WIN_H = IMG_H * S;

  localparam logic [N_COL:0]       WIN_W_E   = (N_COL + 1)'(WIN_W);
  localparam logic [N_FIL:0]       WIN_H_E   = (N_FIL + 1)'(WIN_H);
  localparam logic [N_COL-1:0]     X_MAX     = N_COL'(H_ACT - WIN_W);
  localparam logic [N_FIL-1:0]     Y_MAX     = N_FIL'(V_ACT - WIN_H);
  localparam logic [N_COL-1:0]     COL_LAST  = N_COL'(H_ACT - 1);
  localparam logic [N_FIL-1:0]     ROW_LAST  = N_FIL'(V_ACT - 1);
  localparam logic [N_FIL-1:0]     SUB_MASK  = N_FIL'(S - 1);
  localparam logic [ADDR_W-1:0]    IMG_W_A   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0]    BASE_LAST = ADDR_W'(IMG_W * (IMG_H - 1));

  logic              en_s;
  logic [N_COL-1:0]  x0_s;
  logic [N_FIL-1:0]  y0_s;
  logic [ADDR_W-1:0] row_base;
  logic [ROM_LAT:0]  hit_pipe;
  logic [ROM_LAT:0]  den_pipe;

  logic [N_COL:0]    x_end;
  logic [N_FIL:0]    y_end;
  logic [N_COL-1:0]  rel_col;
  logic [N_FIL-1:0]  rel_row;
  logic              frame_end, in_x, in_y, hit, right_edge, last_sub;

  // Window bounds are one bit wider so a window touching the last column/row cannot wrap.
  assign x_end      = {1'b0, x0_s} + WIN_W_E;
  assign y_end      = {1'b0, y0_s} + WIN_H_E;
  assign in_x       = (columna >= x0_s) && ({1'b0, columna} < x_end);
  assign in_y       = (fila >= y0_s) && ({1'b0, fila} < y_end);
  assign hit        = en_s && DEN && in_x && in_y;
  assign rel_col    = columna - x0_s;
  assign rel_row    = fila - y0_s;
  assign right_edge = ({1'b0, columna} == (x_end - 1'b1));
  assign last_sub   = ((rel_row & SUB_MASK) == SUB_MASK);
  assign frame_end  = DEN && (fila == ROW_LAST) && (columna == COL_LAST);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      en_s     <= 1'b0;
      x0_s     <= '0;
      y0_s     <= '0;
      row_base <= '0;
      rom_addr <= '0;
    end else begin
      if (frame_end) begin
        en_s <= enable;
        x0_s <= (pos_x > X_MAX) ? X_MAX : pos_x;
        y0_s <= (pos_y > Y_MAX) ? Y_MAX : pos_y;
      end
      rom_addr <= hit ? (row_base + ADDR_W'(rel_col >> SCALE_SH)) : '0;
      // Advance one stored row after the last magnified sub-row; the guard keeps the index in range.
      if (frame_end || (DEN && (fila < y0_s))) begin
        row_base <= '0;
      end else if (hit && right_edge && last_sub && (row_base != BASE_LAST)) begin
        row_base <= row_base + IMG_W_A;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      hit_pipe <= '0;
      den_pipe <= '0;
      pix_out  <= BG_COLOR;
      pix_hit  <= 1'b0;
      pix_den  <= 1'b0;
    end else begin
      hit_pipe <= {hit_pipe[ROM_LAT-1:0], hit};
      den_pipe <= {den_pipe[ROM_LAT-1:0], DEN};
      pix_out  <= hit_pipe[ROM_LAT] ? rom_q : BG_COLOR;
      pix_hit  <= hit_pipe[ROM_LAT];
      pix_den  <= den_pipe[ROM_LAT];
    end
  end

endmodule

// File: doc/lcd_image_window.md
Name: lcd_image_window

Overview:
- Successor to the fixed full-screen 1-bit background ROM reader. Places a stored image of IMG_W x IMG_H pixels anywhere in the visible area.
- The image is magnified by 2^SCALE_SH, and pixels are COLOR_DEPTH bits wide.
- Uses linear (dense) ROM addressing, not XY concatenation. Default 200x120 scaled x4 fills 800x480 from 24000 words instead of 491520.
- Sits between the LCD timing generator (fila/columna/DEN) and the pixel colour mux. Works on the single pixel clock.

Parameters:
- H_ACT, 800, visible columns.
- V_ACT, 480, visible rows.
- IMG_W, 200, stored image width in pixels.
- IMG_H, 120, stored image height in pixels.
- SCALE_SH, 2, magnification = S = 2^SCALE_SH. Constraints: IMG_W*S <= H_ACT and IMG_H*S <= V_ACT.
- COLOR_DEPTH, 1, bits per pixel.
- ROM_LAT, 1, ROM read latency in clocks (>=1).
- BG_COLOR, 0, value driven outside the window or when disabled.
- Derived widths: N_COL = CLogB2(H_ACT-1), N_FIL = CLogB2(V_ACT-1), ADDR_W = CLogB2(IMG_W*IMG_H-1).

Ports:
- CLK  in  1  pixel clock; all logic on its rising edge.
- RST_n  in  1  asynchronous active-low reset.
- DEN  in  1  data enable from the timing generator; fila/columna valid when 1.
- fila  in  N_FIL  current row.
- columna  in  N_COL  current column.
- enable  in  1  requested image enable; shadowed per frame.
- pos_x  in  N_COL  requested window left column; shadowed per frame.
- pos_y  in  N_FIL  requested window top row; shadowed per frame.
- rom_addr  out  ADDR_W  ROM address, registered.
- rom_q  in  COLOR_DEPTH  ROM data, valid ROM_LAT clocks after rom_addr.
- pix_out  out  COLOR_DEPTH  pixel colour, registered.
- pix_hit  out  1  pix_out comes from the image.
- pix_den  out  1  DEN delayed to align with pix_out.

Behaviour:
- Reset: rom_addr=0, pix_out=BG_COLOR, pix_hit=0, pix_den=0. Shadows: en_s=0, x0_s=0, y0_s=0. row_base=0. Delay pipes cleared.
- Shadow load (frame_end):
  - Event: an edge sampling DEN=1, fila=V_ACT-1, columna=H_ACT-1.
  - At that edge: en_s<=enable, x0_s<=min(pos_x, H_ACT-IMG_W*S), y0_s<=min(pos_y, V_ACT-IMG_H*S) (saturating clamp).
  - New values are effective from the next sampled pixel. Changes to pos/enable mid-frame have no effect until then.
- Window test (combinational on the sampled inputs):
  - hit = en_s & DEN & x0_s <= columna < x0_s+IMG_W*S & y0_s <= fila < y0_s+IMG_H*S.
- Address stage (1 clock):
  - On hit: rom_addr <= row_base + ((columna-x0_s)>>SCALE_SH).
  - Otherwise rom_addr <= 0.
- row_base register:
  - Increments by IMG_W at the edge sampling hit with columna = x0_s+IMG_W*S-1 and ((fila-y0_s) mod S) = S-1.
  - Cleared at frame_end, and whenever DEN=1 with fila < y0_s.
  - Never exceeds IMG_W*(IMG_H-1) within a frame.
  - At frame_end, the clear takes priority over the increment.
- Alignment pipe:
  - hit and DEN are delayed by 1+ROM_LAT stages.
  - Output register: pix_out <= hit_d ? rom_q : BG_COLOR; pix_hit <= hit_d; pix_den <= DEN_d.
  - Total latency from input sample to outputs = ROM_LAT+2 clocks, fixed.
- DEN low (blanking): no address, row_base or shadow updates except as stated above. Pipes keep shifting.
- Async reset mid-frame: everything returns to reset values immediately. The image is not shown (en_s=0) until the first full frame_end after reset.
- Widths: intermediate sums must be wide enough to hold x0_s+IMG_W*S without overflow (N_COL+1 bits); same for rows. The ROM index never exceeds IMG_W*IMG_H-1.

Test Plan:
- Defaults, enable=1, pos=(0,0), after one frame_end: pixel (0,0) -> rom_addr 0. Pixel (7,0) -> 1. Pixel (799,3) -> 199. Pixel (0,4) -> 200. Pixel (799,479) -> 23999. pix_hit=1 throughout; pix_out equals rom_q 3 clocks after the sample (ROM_LAT=1).
- SCALE_SH=0, IMG 100x50, pos=(10,20): pixel (9,20) -> pix_out=BG_COLOR, pix_hit=0. Pixel (10,20) -> addr 0. Pixel (109,69) -> addr 4999. Pixel (110,69) -> BG.
- pos_x=790 requested with IMG_W*S=400: shadow clamps to 400. Pixel (399,y) -> BG; pixel (400,y) -> hit.
- Change pos_y and enable=0 mid-frame: the current frame is unchanged. Next frame is all BG, pix_hit=0, rom_addr stays 0.
- Assert RST_n=0 for 1 cycle mid-line: outputs go to reset values immediately, and the first frame after reset is all BG. ROM_LAT=3 variant: latency is 5 clocks and pix_den tracks DEN with the same delay.
